// File: rtl/systolic_mm.sv
// N x N output-stationary systolic matrix multiplier with signed/unsigned,
// accumulate-onto-previous, saturating result and start/done/busy handshake.
module systolic_mm #(
  parameter int N         = 3,
  parameter int DATA_SIZE = 8,
  parameter int ACC_SIZE  = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        signed_mode,
  input  logic                        acc_mode,
  input  logic [N*N*DATA_SIZE-1:0]    Mat1_in,
  input  logic [N*N*DATA_SIZE-1:0]    Mat2_in,
  output logic [N*N*ACC_SIZE-1:0]     result,
  output logic                        done,
  output logic                        busy,
  output logic                        overflow
);

  localparam int AW = 2*DATA_SIZE + $clog2(N) + 2;
  localparam int SW = ((AW > ACC_SIZE) ? AW : ACC_SIZE) + 2;
  localparam int CW = $clog2(3*N);
  localparam logic [CW-1:0] LAST = CW'(3*N-3);
  localparam logic signed [SW-1:0] UMAX = {{(SW-ACC_SIZE){1'b0}}, {ACC_SIZE{1'b1}}};
  localparam logic signed [SW-1:0] SMAX = {{(SW-ACC_SIZE+1){1'b0}}, {(ACC_SIZE-1){1'b1}}};
  localparam logic signed [SW-1:0] SMIN = {{(SW-ACC_SIZE+1){1'b1}}, {(ACC_SIZE-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  mode_s;
  logic                  mode_acc;
  logic [DATA_SIZE-1:0]  a_cap  [N][N];
  logic [DATA_SIZE-1:0]  b_cap  [N][N];
  logic [DATA_SIZE-1:0]  a_edge [N];
  logic [DATA_SIZE-1:0]  b_edge [N];
  logic [DATA_SIZE-1:0]  a_in   [N][N];
  logic [DATA_SIZE-1:0]  b_in   [N][N];
  logic [DATA_SIZE-1:0]  a_reg  [N][N];
  logic [DATA_SIZE-1:0]  b_reg  [N][N];
  logic signed [AW-1:0]  prod   [N][N];
  logic signed [AW-1:0]  acc    [N][N];
  logic                  run;
  logic                  clear;
  logic [N*N*ACC_SIZE-1:0] res_next;
  logic                  ovf_next;
  logic signed [SW-1:0]  sum;
  logic signed [SW-1:0]  held_ext;
  logic signed [SW-1:0]  hi;
  logic signed [SW-1:0]  lo;
  logic signed [SW-1:0]  sat;
  logic [ACC_SIZE-1:0]   held;

  assign run   = (state == RUN);
  assign clear = (state == IDLE) && start;

  function automatic logic signed [AW-1:0] ext(input logic [DATA_SIZE-1:0] v, input logic s);
    return {{(AW-DATA_SIZE){s & v[DATA_SIZE-1]}}, v};
  endfunction

  // Skewed edge feed: row i of A / column i of B enters i cycles late, zeros elsewhere.
  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_edge[i] = '0;
      b_edge[i] = '0;
      for (int unsigned k = 0; k < N; k++) begin
        if (run && cnt == CW'(i + k)) begin
          a_edge[i] = a_cap[i][k];
          b_edge[i] = b_cap[k][i];
        end
      end
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N; i++) begin
      a_in[i][0] = a_edge[i];
      b_in[0][i] = b_edge[i];
      for (int unsigned j = 1; j < N; j++) begin
        a_in[i][j] = a_reg[i][j-1];
        b_in[j][i] = b_reg[j-1][i];
      end
    end
    for (int unsigned i = 0; i < N; i++)
      for (int unsigned j = 0; j < N; j++)
        prod[i][j] = ext(a_in[i][j], mode_s) * ext(b_in[i][j], mode_s);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else if (clear) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++) begin
          acc[i][j]   <= '0;
          a_reg[i][j] <= '0;
          b_reg[i][j] <= '0;
        end
    end else if (run) begin
      for (int unsigned i = 0; i < N; i++)
        for (int unsigned j = 0; j < N; j++) begin
          acc[i][j]   <= acc[i][j] + prod[i][j];
          a_reg[i][j] <= a_in[i][j];
          b_reg[i][j] <= b_in[i][j];
        end
    end
  end

  // Held result is reinterpreted in the current mode before being added.
  always_comb begin
    res_next = '0;
    ovf_next = 1'b0;
    sum      = '0;
    held_ext = '0;
    hi       = '0;
    lo       = '0;
    sat      = '0;
    held     = '0;
    for (int unsigned k = 0; k < N*N; k++) begin
      held     = result[(N*N-1-k)*ACC_SIZE +: ACC_SIZE];
      held_ext = mode_s ? {{(SW-ACC_SIZE){held[ACC_SIZE-1]}}, held}
                        : {{(SW-ACC_SIZE){1'b0}}, held};
      sum = {{(SW-AW){acc[k/N][k%N][AW-1]}}, acc[k/N][k%N]};
      if (mode_acc)
        sum = sum + held_ext;
      hi = mode_s ? SMAX : UMAX;
      lo = mode_s ? SMIN : '0;
      if (sum > hi) begin
        sat      = hi;
        ovf_next = 1'b1;
      end else if (sum < lo) begin
        sat      = lo;
        ovf_next = 1'b1;
      end else begin
        sat = sum;
      end
      res_next[(N*N-1-k)*ACC_SIZE +: ACC_SIZE] = sat[ACC_SIZE-1:0];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_s   <= 1'b0;
      mode_acc <= 1'b0;
      result   <= '0;
      done     <= 1'b0;
      busy     <= 1'b0;
      overflow <= 1'b0;
      for (int unsigned r = 0; r < N; r++)
        for (int unsigned c = 0; c < N; c++) begin
          a_cap[r][c] <= '0;
          b_cap[r][c] <= '0;
        end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            for (int unsigned r = 0; r < N; r++)
              for (int unsigned c = 0; c < N; c++) begin
                a_cap[r][c] <= Mat1_in[(N*N-1-(r*N+c))*DATA_SIZE +: DATA_SIZE];
                b_cap[r][c] <= Mat2_in[(N*N-1-(r*N+c))*DATA_SIZE +: DATA_SIZE];
              end
            mode_s   <= signed_mode;
            mode_acc <= acc_mode;
            cnt      <= '0;
            busy     <= 1'b1;
            state    <= RUN;
          end
        end
        RUN: begin
          cnt <= cnt + 1'b1;
          if (cnt == LAST)
            state <= DONE;
        end
        DONE: begin
          result   <= res_next;
          overflow <= ovf_next;
          done     <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_systolic_mm.sv
// Scoreboard bench for systolic_mm: N=3 (8/16-bit) and N=4 (4/12-bit) instances.
`timescale 1ns/1ps
module tb_systolic_mm;
  localparam int LAT3 = 8;
  localparam int LAT4 = 11;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start, sm, am;
  logic [71:0]  m1, m2;
  logic [143:0] res;
  logic         done, busy, ovf;
  logic         start4, sm4, am4;
  logic [63:0]  n1, n2;
  logic [191:0] res4;
  logic         done4, busy4, ovf4;

  int checks = 0, errors = 0, cyc = 0, n_push = 0, n_done = 0;

  typedef struct {
    logic [191:0] r;
    logic         o;
    int           at;
  } exp_t;
  exp_t q3[$];
  exp_t q4[$];

  localparam logic [71:0] A1 = {8'd10, 8'd17, 8'd2, 8'd5, 8'd1, 8'd0, 8'd28, 8'd16, 8'd5};
  localparam logic [71:0] B1 = {8'd0, 8'd20, 8'd8, 8'd21, 8'd2, 8'd32, 8'd4, 8'd0, 8'd1};
  localparam logic [71:0] B2 = {8'd0, 8'd10, 8'd8, 8'd21, 8'd2, 8'd32, 8'd4, 8'd0, 8'd1};
  localparam logic [71:0] ID = {8'd1, 8'd0, 8'd0, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd1};
  localparam logic [143:0] E1 = {16'd365, 16'd234, 16'd626, 16'd21, 16'd102, 16'd72,
                                 16'd356, 16'd592, 16'd741};
  localparam logic [143:0] E2 = {16'd730, 16'd368, 16'd1252, 16'd42, 16'd154, 16'd144,
                                 16'd712, 16'd904, 16'd1482};

  systolic_mm #(.N(3), .DATA_SIZE(8), .ACC_SIZE(16)) dut3 (
    .clk(clk), .reset(reset), .start(start), .signed_mode(sm), .acc_mode(am),
    .Mat1_in(m1), .Mat2_in(m2), .result(res), .done(done), .busy(busy), .overflow(ovf)
  );

  systolic_mm #(.N(4), .DATA_SIZE(4), .ACC_SIZE(12)) dut4 (
    .clk(clk), .reset(reset), .start(start4), .signed_mode(sm4), .acc_mode(am4),
    .Mat1_in(n1), .Mat2_in(n2), .result(res4), .done(done4), .busy(busy4), .overflow(ovf4)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [191:0] got, input logic [191:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (done === 1'b1) begin
      exp_t e;
      n_done++;
      if (q3.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done3: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e = q3.pop_front();
        check("result3", {48'd0, res}, e.r);
        check("overflow3", {191'd0, ovf}, {191'd0, e.o});
        check("latency3", 192'(cyc), 192'(e.at));
      end
    end
  end

  always @(negedge clk) begin
    if (done4 === 1'b1) begin
      exp_t e;
      if (q4.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_done4: got done=1 expected done=0 at cycle %0d", cyc);
      end else begin
        e = q4.pop_front();
        check("result4", res4, e.r);
        check("overflow4", {191'd0, ovf4}, {191'd0, e.o});
        check("latency4", 192'(cyc), 192'(e.at));
      end
    end
  end

  // Called at a negedge; returns at the negedge where done is high so the
  // next call starts back-to-back.
  task automatic job(input logic [71:0] a, input logic [71:0] b, input logic s,
                     input logic ac, input logic [143:0] er, input logic eo, input bit mid);
    exp_t e;
    int   bc;
    m1 = a; m2 = b; sm = s; am = ac; start = 1'b1;
    e.r = {48'd0, er}; e.o = eo; e.at = cyc + 1 + LAT3;
    q3.push_back(e);
    n_push++;
    @(negedge clk);
    start = 1'b0; m1 = ~a; m2 = ~b; sm = ~s; am = ~ac;
    bc = 0;
    for (int k = 0; k < LAT3; k++) begin
      if (busy === 1'b1) bc++;
      start = (mid && k == 3) ? 1'b1 : 1'b0;
      @(negedge clk);
    end
    start = 1'b0;
    check("busy_cycles", 192'(bc), 192'(LAT3));
    check("busy_low_at_done", {191'd0, busy}, 192'd0);
  endtask

  initial begin
    start = 0; sm = 0; am = 0; m1 = '0; m2 = '0;
    start4 = 0; sm4 = 0; am4 = 0; n1 = '0; n2 = '0;
    #2 reset = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_result", {48'd0, res}, 192'd0);
    check("reset_done", {191'd0, done}, 192'd0);
    check("reset_busy", {191'd0, busy}, 192'd0);
    check("reset_overflow", {191'd0, ovf}, 192'd0);
    reset = 1'b1;
    @(negedge clk);

    job(A1, B1, 1'b0, 1'b0, E1, 1'b0, 1'b0);
    job(A1, B2, 1'b0, 1'b1, E2, 1'b0, 1'b1);
    job({9{8'hFF}}, {9{8'hFF}}, 1'b0, 1'b0, {9{16'hFFFF}}, 1'b1, 1'b0);
    job({9{8'h80}}, {9{8'h80}}, 1'b1, 1'b0, {9{16'h7FFF}}, 1'b1, 1'b0);
    job(ID, {9{8'hFF}}, 1'b1, 1'b0, {9{16'hFFFF}}, 1'b0, 1'b0);
    job(ID, {9{8'hFF}}, 1'b0, 1'b0, {9{16'd255}}, 1'b0, 1'b0);
    job({9{8'hFF}}, {9{8'hFF}}, 1'b0, 1'b0, {9{16'hFFFF}}, 1'b1, 1'b0);

    // Aborted run: no scoreboard entry, any done here is spurious.
    m1 = A1; m2 = B1; sm = 0; am = 0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_reset_result", {48'd0, res}, 192'd0);
    check("async_reset_done", {191'd0, done}, 192'd0);
    check("async_reset_busy", {191'd0, busy}, 192'd0);
    check("async_reset_overflow", {191'd0, ovf}, 192'd0);
    repeat (4) @(negedge clk);
    reset = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_release", {190'd0, done, busy}, 192'd0);

    job(A1, B1, 1'b0, 1'b1, E1, 1'b0, 1'b0);

    begin
      exp_t e;
      n1 = {16{4'hF}}; n2 = {16{4'hF}}; sm4 = 0; am4 = 0; start4 = 1'b1;
      e.r = {16{12'd900}}; e.o = 1'b0; e.at = cyc + 1 + LAT4;
      q4.push_back(e);
      @(negedge clk);
      start4 = 1'b0; n1 = '0; n2 = '0;
      repeat (LAT4 + 1) @(negedge clk);
    end

    for (int i = 0; i < 50 && (q3.size() != 0 || q4.size() != 0); i++)
      @(negedge clk);
    check("queues_drained", 192'(q3.size() + q4.size()), 192'd0);
    check("done_count", 192'(n_done), 192'(n_push));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/systolic_mm.md
# systolic_mm

Parametrised N×N output-stationary systolic matrix multiplier, the next generation of the fixed 3×3 array. It generalises matrix order and data/accumulator widths, and adds signed/unsigned mode, accumulate-onto-previous-result mode, saturation with an overflow flag, and a busy indicator. It sits behind the same flat-bus start/done interface, so existing drivers carry over with wider buses.

## Interface
- N, 3: matrix order (rows = cols = N), ≥2
- DATA_SIZE, 8: operand element width
- ACC_SIZE, 16: result element width, ≥ DATA_SIZE
- clk  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low; all state cleared while low
- start  in  1  one-cycle request; sampled only in IDLE
- signed_mode  in  1  1 = two's-complement operands/results; captured at start
- acc_mode  in  1  1 = add new product onto held result; captured at start
- Mat1_in  in  N*N*DATA_SIZE  matrix A, row-major, element (r,c) at index r*N+c counted from MSB
- Mat2_in  in  N*N*DATA_SIZE  matrix B, same packing
- result  out  N*N*ACC_SIZE  C = A·B (+ previous C if acc_mode), same packing, held until next done
- done  out  1  one-cycle pulse when result updates
- busy  out  1  high from the start edge until done asserts
- overflow  out  1  any element of the last result saturated; updates with done

## Operation
- States: IDLE, RUN, DONE.
- IDLE: start=1 → capture Mat1_in, Mat2_in, signed_mode, acc_mode into internal registers; clear PE accumulators; go to RUN. Inputs may change freely after the start edge.
- RUN: N×N grid of PEs. Row i of A enters the left edge delayed i cycles; column j of B enters the top delayed j cycles; zeros fill the skew. Each PE: acc += a·b; forward a right and b down, one register stage each. Cycle counter runs 0..3N-3, then → DONE.
- DONE: per element, sum = PE acc (+ held result if acc_mode); saturate to ACC_SIZE; write result, set overflow, pulse done; → IDLE.
- Arithmetic: product 2*DATA_SIZE bits, sign- or zero-extended per mode; internal accumulator 2*DATA_SIZE+clog2(N)+2 bits, no internal wrap. Held result is reinterpreted in the current mode. Saturation bounds: unsigned 0..2^ACC_SIZE−1; signed −2^(ACC_SIZE−1)..2^(ACC_SIZE−1)−1.
- start while busy: ignored, no queuing.
- reset low at any time, including mid-RUN: state → IDLE, all PE/pipeline registers cleared, result=0, done=0, busy=0, overflow=0. acc_mode after reset accumulates onto 0.

## Timing
- start sampled high at edge E0 → busy=1 after E0; RUN occupies 3N−2 cycles; at edge E0+3N−1 result/overflow update, done=1, busy=0; done drops at E0+3N.
- Latency start→done = 3N−1 cycles (8 for N=3, 11 for N=4).
- Earliest next start: the cycle done is high (state already IDLE) → sampled at E0+3N.
- Throughput: one multiply per 3N−1 cycles; no overlap between jobs.
- Outputs registered; no combinational path from inputs to outputs.

## Test plan
- N=3 unsigned, acc_mode=0, A=[[10,17,2],[5,1,0],[28,16,5]], B=[[0,20,8],[21,2,32],[4,0,1]] → done exactly 8 cycles after start, result [[365,234,626],[21,102,72],[356,592,741]], overflow=0, busy high for 8 cycles.
- Back-to-back start with acc_mode=1, same A, B with 20→10 → result [[730,368,1252],[42,154,144],[712,904,1482]]; a start pulsed mid-run is ignored (exactly one done).
- Saturation: unsigned all 0xFF → every element 65535, overflow=1; signed all 0x80 (−128) → every element 32767 (0x7FFF), overflow=1; next clean run clears overflow.
- Signed: A = identity, B = all −1 (0xFF) → every element 0xFFFF (−1), overflow=0; same inputs unsigned → every element 255.
- Reset low 4 cycles into a run → result=0, done/busy/overflow=0 immediately (asynchronous); no stale done after release; a fresh run yields correct values.
- N=4, DATA_SIZE=4, ACC_SIZE=12: A = B = all 15 → done 11 cycles after start, every element 900, overflow=0.
